pid_err_calc_mc: RTL and testbench
==================================

Name: pid_err_calc_mc

Overview:
Parametrised, multi-channel successor to the three-axis PID error calculator. For each channel it computes the proportional error (tgt - cur), the saturating integral of the error and the derivative (err - prev_err). All values are signed two's complement. Channels are processed time-multiplexed through one arithmetic lane, one channel per cycle. Results are published atomically with an out_valid pulse for the downstream PID multiply stage.

Parameters:
- NCH, 3: number of channels (axes); must be at least 1.
- W, 24: width of target, current, error and derivative values (signed).
- IW, 24: width of the integral accumulator and i_err output (signed); must be at least W.
- I_LIMIT, 2**(IW-1)-1: symmetric integral clamp magnitude; the integral is held within [-I_LIMIT, +I_LIMIT].

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  sample strobe; accepted only when in_ready=1.
- in_ready  out  1  high when the block is IDLE.
- tgt  in  NCH*W  packed targets; channel k occupies bits [k*W +: W].
- cur  in  NCH*W  packed measured values; same packing as tgt.
- i_clr  in  1  clears all integrators and prev_err at the next accepted sample.
- err  out  NCH*W  proportional errors.
- i_err  out  NCH*IW  integrals.
- d_err  out  NCH*W  derivatives.
- out_valid  out  1  one-cycle pulse when all outputs have been updated.
- sat_flag  out  NCH  per channel: set if the error or the integral saturated in the last update.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready=1; out_valid=0; and all of the following cleared to 0:
  - err, i_err, d_err, sat_flag;
  - internal integrators, prev_err, the tgt/cur latches and the channel counter.
- Reset applied mid-operation aborts the update in progress. No out_valid is produced for the aborted sample.
- FSM states are IDLE, CALC and DONE.
  - IDLE: on in_valid=1, latch tgt, cur and i_clr; set ch=0; go to CALC. in_ready=0 in every state except IDLE.
  - CALC: each cycle, process channel ch into shadow registers. If ch==NCH-1, go to DONE; otherwise ch=ch+1.
  - DONE: copy the shadow registers to err, i_err, d_err and sat_flag; assert out_valid for one cycle; go to IDLE.
- Latency: accept edge to out_valid is NCH+1 cycles. With back-to-back in_valid, throughput is one sample per NCH+2 cycles.
- in_valid while not IDLE is ignored and not queued.
- Outputs hold their values between out_valid pulses.
- Per-channel arithmetic:
  - e = sat_W(tgt_k - cur_k), computed at W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1].
  - If the latched i_clr=1: i_old=0 and p_old=0 for every channel.
  - i_new = clamp(i_old + sext(e), ±I_LIMIT), computed at IW+1 bits.
  - d = sat_W(e - p_old).
  - prev_err_k is updated to e.
  - sat_flag_k is set if any clamp was active for that channel.
- First sample after reset or clear: d_err equals err, because prev_err=0.
- Integral clamp acts as anti-windup: further error of the same sign leaves the integral pinned at the limit. Error of opposite sign immediately reduces it.
- i_clr is sampled only together with an accepted in_valid.

Decomposition:
- Package pid_err_pkg:
  - signed saturate/clamp functions sat_w(value, width) and clamp_lim(value, lim);
  - FSM state enum (IDLE, CALC, DONE);
  - channel index width constant, $clog2(NCH) with a minimum of 1.
- Sub-module pid_err_lane: combinational single-channel arithmetic.
  - Inputs: tgt, cur, i_old, p_old, clr.
  - Outputs: e, i_new, d, sat.
- The top level owns the FSM, channel mux, shadow registers and output registers.

Test Plan:
1. NCH=3, tgt={1000,2000,3000}, cur={900,1900,2900}, pulse in_valid -> out_valid after 4 cycles; err=100, i_err=100, d_err=100 on all channels.
2. Continue from 1 with cur={950,1950,2950} -> err=50, i_err=150, d_err=-50. Then cur={1100,2100,3100} -> err=-100, i_err=50, d_err=-150.
3. Saturation, ch0 tgt=24'h7FFFFF, cur=24'h800000 -> err=24'h7FFFFF, sat_flag[0]=1.
   - With I_LIMIT=1000 and repeated err=400: i_err goes 400, 800, 1000, 1000.
   - Then err=-400 -> i_err=600.
4. in_valid held high continuously with changing data -> exactly one sample accepted per NCH+2 cycles. Data presented while in_ready=0 has no effect on the outputs.
5. i_clr=1 with an accepted sample of err=70 after prior integral 500 -> i_err=70, d_err=70.
6. rst_n low for one cycle during CALC -> no out_valid follows; all outputs=0 and in_ready=1 the cycle after reset is released. The next sample behaves as in scenario 1.

Source files
------------

// File: rtl/pid_err_pkg.sv
// Shared types and saturation helpers for the multi-channel PID error calculator.
package pid_err_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the channel index for a given channel count.
    // A single channel still needs a one-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a wide signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                                 input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    // Clamp a wide signed value into the symmetric range [-lim, +lim].
    function automatic logic signed [63:0] clamp_lim(input logic signed [63:0] value,
                                                     input logic signed [63:0] lim);
        if (value > lim) begin
            return lim;
        end else if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage

// File: rtl/pid_err_calc_mc_lane.sv
// Combinational single-channel arithmetic: saturated error, anti-windup
// integral and saturated derivative. All values are signed two's complement.
// I_LIMIT must not exceed 2**(IW-1)-1 so the clamped integral fits in IW bits.
module pid_err_lane
    import pid_err_pkg::*;
#(
    parameter int                 W       = 24,
    parameter int                 IW      = 24,
    parameter logic signed [63:0] I_LIMIT = (64'sd1 <<< (IW - 1)) - 64'sd1
) (
    input  logic [W-1:0]  tgt,
    input  logic [W-1:0]  cur,
    input  logic [IW-1:0] i_old,
    input  logic [W-1:0]  p_old,
    input  logic          clr,
    output logic [W-1:0]  e,
    output logic [IW-1:0] i_new,
    output logic [W-1:0]  d,
    output logic          sat
);

    logic signed [63:0] diff;
    logic signed [63:0] e_s;
    logic signed [63:0] io;
    logic signed [63:0] po;
    logic signed [63:0] isum;
    logic signed [63:0] i_s;
    logic signed [63:0] dd;
    logic signed [63:0] d_s;

    // Wide intermediate arithmetic, then clamp; a clear zeroes the history.
    always_comb begin
        diff  = 64'($signed(tgt)) - 64'($signed(cur));
        e_s   = sat_w(diff, W);
        io    = clr ? 64'sd0 : 64'($signed(i_old));
        po    = clr ? 64'sd0 : 64'($signed(p_old));
        isum  = io + e_s;
        i_s   = clamp_lim(isum, I_LIMIT);
        dd    = e_s - po;
        d_s   = sat_w(dd, W);
        e     = e_s[W-1:0];
        i_new = i_s[IW-1:0];
        d     = d_s[W-1:0];
        sat   = (e_s != diff) || (i_s != isum) || (d_s != dd);
    end

endmodule

// File: rtl/pid_err_calc_mc.sv
// Multi-channel PID error calculator. One shared arithmetic lane processes
// one channel per cycle into shadow registers; results are published
// atomically together with a one-cycle out_valid pulse.
module pid_err_calc_mc
    import pid_err_pkg::*;
#(
    parameter int                 NCH     = 3,
    parameter int                 W       = 24,
    parameter int                 IW      = 24,
    parameter logic signed [63:0] I_LIMIT = (64'sd1 <<< (IW - 1)) - 64'sd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*W-1:0]  tgt,
    input  logic [NCH*W-1:0]  cur,
    input  logic              i_clr,
    output logic [NCH*W-1:0]  err,
    output logic [NCH*IW-1:0] i_err,
    output logic [NCH*W-1:0]  d_err,
    output logic              out_valid,
    output logic [NCH-1:0]    sat_flag
);

    localparam int               CH_W = ch_width(NCH);
    localparam logic [CH_W-1:0]  LAST = CH_W'(NCH - 1);

    state_t state;
    state_t state_nxt;

    logic [CH_W-1:0]   ch;
    logic [NCH*W-1:0]  tgt_q;
    logic [NCH*W-1:0]  cur_q;
    logic              clr_q;

    logic [IW-1:0]     integ [NCH];
    logic [W-1:0]      prev  [NCH];

    logic [NCH*W-1:0]  sh_err;
    logic [NCH*IW-1:0] sh_ierr;
    logic [NCH*W-1:0]  sh_derr;
    logic [NCH-1:0]    sh_sat;

    logic [W-1:0]      lane_tgt;
    logic [W-1:0]      lane_cur;
    logic [IW-1:0]     lane_i_old;
    logic [W-1:0]      lane_p_old;
    logic [W-1:0]      lane_e;
    logic [IW-1:0]     lane_i;
    logic [W-1:0]      lane_d;
    logic              lane_sat;

    // Select the operands of the channel currently being processed.
    always_comb begin
        lane_tgt   = tgt_q[ch*W +: W];
        lane_cur   = cur_q[ch*W +: W];
        lane_i_old = integ[ch];
        lane_p_old = prev[ch];
    end

    pid_err_lane #(
        .W       (W),
        .IW      (IW),
        .I_LIMIT (I_LIMIT)
    ) u_lane (
        .tgt   (lane_tgt),
        .cur   (lane_cur),
        .i_old (lane_i_old),
        .p_old (lane_p_old),
        .clr   (clr_q),
        .e     (lane_e),
        .i_new (lane_i),
        .d     (lane_d),
        .sat   (lane_sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the block only accepts samples while idle.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (ch == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture an accepted sample and step the channel counter during CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_q <= '0;
            cur_q <= '0;
            clr_q <= 1'b0;
            ch    <= '0;
        end else if (state == IDLE && in_valid) begin
            tgt_q <= tgt;
            cur_q <= cur;
            clr_q <= i_clr;
            ch    <= '0;
        end else if (state == CALC && ch != LAST) begin
            ch <= ch + 1'b1;
        end
    end

    // Write the lane result into the shadow registers and channel history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_err  <= '0;
            sh_ierr <= '0;
            sh_derr <= '0;
            sh_sat  <= '0;
            for (int k = 0; k < NCH; k++) begin
                integ[k] <= '0;
                prev[k]  <= '0;
            end
        end else if (state == CALC) begin
            sh_err[ch*W +: W]    <= lane_e;
            sh_ierr[ch*IW +: IW] <= lane_i;
            sh_derr[ch*W +: W]   <= lane_d;
            sh_sat[ch]           <= lane_sat;
            integ[ch]            <= lane_i;
            prev[ch]             <= lane_e;
        end
    end

    // Publish all channels at once and pulse out_valid alongside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err       <= '0;
            i_err     <= '0;
            d_err     <= '0;
            sat_flag  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            if (state == DONE) begin
                err      <= sh_err;
                i_err    <= sh_ierr;
                d_err    <= sh_derr;
                sat_flag <= sh_sat;
            end
        end
    end

endmodule

// File: tb/tb_pid_err_calc_mc.sv
// Directed self-checking bench for pid_err_calc_mc (3 channels, 24-bit,
// integral limit 1000) with hand-computed expected values.
module tb_pid_err_calc_mc;

    localparam int NCH = 3;
    localparam int W   = 24;
    localparam int IW  = 24;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NCH*W-1:0]  tgt;
    logic [NCH*W-1:0]  cur;
    logic              i_clr;
    logic [NCH*W-1:0]  err;
    logic [NCH*IW-1:0] i_err;
    logic [NCH*W-1:0]  d_err;
    logic              out_valid;
    logic [NCH-1:0]    sat_flag;

    int vec_count;
    int miscompares;

    pid_err_calc_mc #(
        .NCH     (NCH),
        .W       (W),
        .IW      (IW),
        .I_LIMIT (64'sd1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tgt       (tgt),
        .cur       (cur),
        .i_clr     (i_clr),
        .err       (err),
        .i_err     (i_err),
        .d_err     (d_err),
        .out_valid (out_valid),
        .sat_flag  (sat_flag)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] s24(input int v);
        return {40'd0, 24'(v)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkChannel(input int k, input int e, input int i, input int d,
                                input logic s);
        checkOutput($sformatf("err%0d", k),   {40'd0, err[k*W +: W]},    s24(e));
        checkOutput($sformatf("i_err%0d", k), {40'd0, i_err[k*IW +: IW]}, s24(i));
        checkOutput($sformatf("d_err%0d", k), {40'd0, d_err[k*W +: W]},  s24(d));
        checkOutput($sformatf("sat%0d", k),   {63'd0, sat_flag[k]},      {63'd0, s});
    endtask

    // Pulse one sample in, wait (bounded) for out_valid and check the latency.
    task automatic applyStimulus(input int t0, input int t1, input int t2,
                                 input int c0, input int c1, input int c2,
                                 input logic clr);
        int cycles;
        @(negedge clk);
        checkOutput("in_ready_before", {63'd0, in_ready}, 64'd1);
        tgt      = {24'(t2), 24'(t1), 24'(t0)};
        cur      = {24'(c2), 24'(c1), 24'(c0)};
        i_clr    = clr;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        i_clr    = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", 64'(cycles), 64'd4);
    endtask

    initial begin
        int exp_e [3];
        int exp_i [3];
        int exp_d [3];
        int pulses;
        int idx;

        vec_count   = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        i_clr    = 1'b0;
        tgt      = '0;
        cur      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        checkOutput("rst_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        for (int k = 0; k < NCH; k++) checkChannel(k, 0, 0, 0, 1'b0);

        // Basic error / integral / derivative
        applyStimulus(1000, 2000, 3000, 900, 1900, 2900, 1'b0);
        for (int k = 0; k < NCH; k++) checkChannel(k, 100, 100, 100, 1'b0);
        applyStimulus(1000, 2000, 3000, 950, 1950, 2950, 1'b0);
        for (int k = 0; k < NCH; k++) checkChannel(k, 50, 150, -50, 1'b0);
        applyStimulus(1000, 2000, 3000, 1100, 2100, 3100, 1'b0);
        for (int k = 0; k < NCH; k++) checkChannel(k, -100, 50, -150, 1'b0);

        // Error saturation and integral anti-windup
        applyStimulus(8388607, 400, 0, -8388608, 0, 400, 1'b1);
        checkChannel(0, 8388607, 1000, 8388607, 1'b1);
        checkChannel(1, 400, 400, 400, 1'b0);
        checkChannel(2, -400, -400, -400, 1'b0);
        applyStimulus(0, 400, 0, 0, 0, 400, 1'b0);
        checkChannel(0, 0, 1000, -8388607, 1'b0);
        checkChannel(1, 400, 800, 0, 1'b0);
        checkChannel(2, -400, -800, 0, 1'b0);
        applyStimulus(-8388608, 400, 0, 8388607, 0, 400, 1'b0);
        checkChannel(0, -8388608, -1000, -8388608, 1'b1);
        checkChannel(1, 400, 1000, 0, 1'b1);
        checkChannel(2, -400, -1000, 0, 1'b1);
        applyStimulus(0, 400, 0, 1, 0, 400, 1'b0);
        checkChannel(0, -1, -1000, 8388607, 1'b1);
        checkChannel(1, 400, 1000, 0, 1'b1);
        checkChannel(2, -400, -1000, 0, 1'b1);
        applyStimulus(1, 0, 400, 0, 400, 0, 1'b0);
        checkChannel(0, 1, -999, 2, 1'b0);
        checkChannel(1, -400, 600, -800, 1'b0);
        checkChannel(2, 400, -600, 800, 1'b0);

        // Integral clear
        applyStimulus(500, 500, 500, 0, 0, 0, 1'b1);
        for (int k = 0; k < NCH; k++) checkChannel(k, 500, 500, 500, 1'b0);
        applyStimulus(70, 70, 70, 0, 0, 0, 1'b1);
        for (int k = 0; k < NCH; k++) checkChannel(k, 70, 70, 70, 1'b0);

        // in_valid held high with data changing every cycle
        exp_e = '{1, 6, 11};
        exp_i = '{71, 77, 88};
        exp_d = '{-69, 5, 5};
        @(negedge clk);
        tgt      = {24'd1, 24'd1, 24'd1};
        cur      = '0;
        in_valid = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            checkOutput($sformatf("hold_valid_n%0d", n), {63'd0, out_valid},
                        {63'd0, (n == 4 || n == 9 || n == 14)});
            checkOutput($sformatf("hold_ready_n%0d", n), {63'd0, in_ready},
                        {63'd0, (n == 4 || n == 9 || n >= 14)});
            if (n == 4 || n == 9 || n == 14) begin
                idx = (n - 4) / 5;
                checkChannel(0, exp_e[idx], exp_i[idx], exp_d[idx], 1'b0);
            end
            tgt = {24'(n + 2), 24'(n + 2), 24'(n + 2)};
            if (n >= 10) in_valid = 1'b0;
        end

        // Reset in the middle of CALC aborts the sample
        tgt      = {24'd5, 24'd5, 24'd5};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        for (int k = 0; k < NCH; k++) checkChannel(k, 0, 0, 0, 1'b0);
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("abort_pulses", 64'(pulses), 64'd0);
        applyStimulus(1000, 2000, 3000, 900, 1900, 2900, 1'b0);
        for (int k = 0; k < NCH; k++) checkChannel(k, 100, 100, 100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
